// File: rtl/sr_bank_driver_pkg.sv
// sr_bank_driver_pkg
// Shared types and helpers for the SR flip-flop bank excitation driver.
//   state_t   : driver FSM states
//   sr_excite : per-bit {S,R} excitation from (target, shadow, force)
package sr_bank_driver_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        PULSE  = 2'd1,
        SETTLE = 2'd2,
        CHECK  = 2'd3
    } state_t;

    // Returns {S,R} for one bit. The pair is never 2'b11: with force the
    // two terms are complements, without force they need t and ~t together.
    function automatic logic [1:0] sr_excite(input logic t, input logic s, input logic frc);
        logic set_b;
        logic rst_b;
        if (frc) begin
            set_b = t;
            rst_b = ~t;
        end else begin
            set_b = t & ~s;
            rst_b = ~t & s;
        end
        return {set_b, rst_b};
    endfunction

endpackage

// File: rtl/sr_bank_driver_timer.sv
// sr_bank_driver_timer
// Loadable down-counter supplying the pulse and settle durations.
// Ports:
//   clk, rst_n : clock, async active-low reset
//   load       : load load_val this cycle (takes priority over en)
//   load_val   : value to load (duration - 1)
//   en         : decrement, saturating at zero
//   tc         : terminal count, high while the count is zero
module sr_bank_driver_timer #(
    parameter int CNT_W = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             load,
    input  logic [CNT_W-1:0] load_val,
    input  logic             en,
    output logic             tc
);

    logic [CNT_W-1:0] count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (en && (count != '0)) begin
            count <= count - 1'b1;
        end
    end

    assign tc = (count == '0);

endmodule

// File: rtl/sr_bank_driver.sv
// sr_bank_driver
// Initiator side of an SR flip-flop bank: accepts a target word, drives
// per-bit S/R pulses against a shadow copy of the bank, waits a settle
// time, and optionally compares the bank readback.
// Build option: SR_BANK_DRIVER_READBACK_EN enables the q_fb compare and
// the sticky err flag; without it err is tied low and q_fb/err_clr unused.
// Ports:
//   clk, rst_n         : clock, async active-low reset
//   wr_valid, wr_ready : target word handshake (ready only in IDLE)
//   wr_data, wr_force  : target word; force drives every bit
//   s, r               : registered set/reset excitation, never both high
//   q_fb               : bank Q readback
//   busy, done         : not-idle flag, one-cycle completion pulse
//   err, err_clr       : sticky readback mismatch and its clear
//   shadow             : driver's model of the bank contents
//
// state  | meaning
// IDLE   | waiting for a target word, wr_ready high
// PULSE  | S/R excitation held for PULSE_CYC cycles
// SETTLE | S=R=0 for SETTLE_CYC cycles
// CHECK  | one cycle, done high, readback compared
module sr_bank_driver
    import sr_bank_driver_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PULSE_CYC  = 1,
    parameter int SETTLE_CYC = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_valid,
    output logic             wr_ready,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             wr_force,
    output logic [WIDTH-1:0] s,
    output logic [WIDTH-1:0] r,
    input  logic [WIDTH-1:0] q_fb,
    output logic             busy,
    output logic             done,
    output logic             err,
    input  logic             err_clr,
    output logic [WIDTH-1:0] shadow
);

    localparam int CNT_MAX = (PULSE_CYC > SETTLE_CYC) ? PULSE_CYC : SETTLE_CYC;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    state_t           state, state_nxt;
    logic [WIDTH-1:0] tgt, tgt_nxt;
    logic [WIDTH-1:0] s_nxt, r_nxt, shadow_nxt;
    logic [WIDTH-1:0] exc_s, exc_r;
    logic             tmr_load, tmr_en, tmr_tc;
    logic [CNT_W-1:0] tmr_val;

    sr_bank_driver_timer #(
        .CNT_W (CNT_W)
    ) u_timer (
        .clk      (clk),
        .rst_n    (rst_n),
        .load     (tmr_load),
        .load_val (tmr_val),
        .en       (tmr_en),
        .tc       (tmr_tc)
    );

    always_comb begin
        exc_s = '0;
        exc_r = '0;
        for (int i = 0; i < WIDTH; i++) begin
            {exc_s[i], exc_r[i]} = sr_excite(wr_data[i], shadow[i], wr_force);
        end
    end

    always_comb begin
        state_nxt  = state;
        tgt_nxt    = tgt;
        shadow_nxt = shadow;
        s_nxt      = '0;
        r_nxt      = '0;
        tmr_load   = 1'b0;
        tmr_en     = 1'b0;
        tmr_val    = CNT_W'(PULSE_CYC - 1);
        unique case (state)
            IDLE: begin
                if (wr_valid) begin
                    tgt_nxt = wr_data;
                    if ((exc_s | exc_r) != '0) begin
                        state_nxt = PULSE;
                        s_nxt     = exc_s;
                        r_nxt     = exc_r;
                        tmr_load  = 1'b1;
                    end else begin
                        // Nothing to drive: bank already matches the target.
                        state_nxt  = CHECK;
                        shadow_nxt = wr_data;
                    end
                end
            end
            PULSE: begin
                if (tmr_tc) begin
                    state_nxt  = SETTLE;
                    shadow_nxt = tgt;
                    tmr_load   = 1'b1;
                    tmr_val    = CNT_W'(SETTLE_CYC - 1);
                end else begin
                    s_nxt  = s;
                    r_nxt  = r;
                    tmr_en = 1'b1;
                end
            end
            SETTLE: begin
                if (tmr_tc) begin
                    state_nxt = CHECK;
                end else begin
                    tmr_en = 1'b1;
                end
            end
            CHECK: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state  <= IDLE;
            tgt    <= '0;
            shadow <= '0;
            s      <= '0;
            r      <= '0;
        end else begin
            state  <= state_nxt;
            tgt    <= tgt_nxt;
            shadow <= shadow_nxt;
            s      <= s_nxt;
            r      <= r_nxt;
        end
    end

    assign wr_ready = (state == IDLE);
    assign busy     = (state != IDLE);
    assign done     = (state == CHECK);

`ifdef SR_BANK_DRIVER_READBACK_EN
    // Mismatch set takes priority over a coincident clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err <= 1'b0;
        end else if ((state == CHECK) && (q_fb != shadow)) begin
            err <= 1'b1;
        end else if (err_clr) begin
            err <= 1'b0;
        end
    end
`else
    logic unused_readback;
    assign unused_readback = ^{q_fb, err_clr};
    assign err = 1'b0;
`endif

endmodule
